// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter.
//   req      : per-requester "byte pending" level (4 requesters)
//   data_in  : requester i byte on data_in[8i+7:8i]
//   ack      : one-hot, one-cycle pulse when a requester's byte is latched
//   grant_id : owner of the current or most recent frame
//   busy     : high while a frame is on the line
//   tx       : serial line, idle-high 8N1
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx;

  modport master (output req, data_in, input ack, grant_id, busy, tx);
  modport slave  (input req, data_in, output ack, grant_id, busy, tx);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of an 8N1 UART transmitter.
// Four requesters hold req[i] until ack[i]; the winner's byte is latched on
// the grant edge and shifted out LSB first. Back-to-back frames start on the
// last STOP cycle so there is no idle gap when requests are pending.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of uart_tx_arbiter_if (req, data_in in; ack,
//           grant_id, busy, tx out, all registered)
module uart_tx_arbiter #(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned BAUD_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int unsigned TICK_W     = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_TICKS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        rr_q, rr_d;
  logic [3:0]        ack_q, ack_d;
  logic [1:0]        gid_q, gid_d;
  logic              busy_q, busy_d;
  logic              tx_q, tx_d;

  logic              sel_valid;
  logic [1:0]        sel_idx;
  logic [1:0]        cand;
  logic [7:0]        sel_byte;
  logic              tick_last;
  logic              grant;

  // Round-robin pick: first pending requester after rr_q, wrapping at 4
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_q + 2'(k);
      if (!sel_valid && bus.req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign sel_byte  = bus.data_in[{sel_idx, 3'b000} +: 8];
  assign tick_last = (tick_q == TICK_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rr_d    = rr_q;
    ack_d   = 4'b0000;
    gid_d   = gid_q;
    grant   = 1'b0;
    busy_d  = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        grant = sel_valid;
      end
      S_START: begin
        if (tick_last) begin
          tick_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick_last) begin
          tick_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick_last) begin
          tick_d = '0;
          bit_d  = 3'd0;
          if (sel_valid) begin
            grant = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Grant edge, shared by IDLE and the last STOP cycle
    if (grant) begin
      state_d = S_START;
      shift_d = sel_byte;
      ack_d   = 4'b0001 << sel_idx;
      gid_d   = sel_idx;
      rr_d    = sel_idx;
      tick_d  = '0;
      bit_d   = 3'd0;
    end

    // Line level follows the state being entered so tx is registered
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      rr_q    <= 2'd3;
      ack_q   <= 4'b0000;
      gid_q   <= 2'd0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;
  assign bus.tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter at CLK_FREQ=400, BAUD_RATE=100 (4 ticks per bit).
// A frame-position model predicts tx/busy/ack/grant_id every cycle; directed
// scenarios add literal expectations for frames, grant order and spacing.
module tb_uart_tx_arbiter;
  localparam int unsigned CLK_FREQ  = 400;
  localparam int unsigned BAUD_RATE = 100;
  localparam int BT    = 4;
  localparam int FRAME = 10 * BT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model: a frame is "active" for FRAME cycles after its grant edge;
  // m_pos is the cycle index within the frame.
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'd0;
  logic [1:0] m_owner  = 2'd0;
  logic [1:0] m_rr     = 2'd3;
  logic [3:0] m_ack    = 4'd0;

  function automatic int pick(logic [3:0] r, logic [1:0] p);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (int'(p) + k) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    bit can;
    int idx;
    if (!rst_n) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_owner  = 2'd0;
      m_rr     = 2'd3;
      m_ack    = 4'd0;
    end else begin
      can   = !m_active || (m_pos == FRAME - 1);
      m_ack = 4'd0;
      if (m_active) begin
        if (m_pos == FRAME - 1) m_active = 1'b0;
        else m_pos = m_pos + 1;
      end
      idx = pick(bus.req, m_rr);
      if (can && idx >= 0) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_byte   = bus.data_in[8*idx +: 8];
        m_owner  = 2'(idx);
        m_rr     = 2'(idx);
        m_ack    = 4'(1 << idx);
      end
    end
  end

  function automatic logic exp_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / BT;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[slot-1];
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: advance to the falling edge and compare against the model
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      check("tx", 32'(bus.tx), 32'(exp_tx()));
      check("busy", 32'(bus.busy), 32'(m_active));
      check("ack", 32'(bus.ack), 32'(m_ack));
      check("grant_id", 32'(bus.grant_id), 32'(m_owner));
    end
  endtask

  task automatic wait_ack(output logic [3:0] a, output int at);
    a  = 4'd0;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.ack != 4'd0) begin
        a  = bus.ack;
        at = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL ack_wait: no ack within 200 cycles (cycle %0d)", cyc);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) return;
      tick();
    end
    total++;
    bad++;
    $display("FAIL idle_wait: busy still high after 200 cycles (cycle %0d)", cyc);
  endtask

  // Called on the ack cycle (frame position 0); samples each bit mid-period.
  task automatic capture(input bit disturb, output logic [9:0] bits, output int busy_n);
    bits   = 10'd0;
    busy_n = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i % BT == 2) bits[i/BT] = bus.tx;
      if (bus.busy) busy_n++;
      if (disturb) begin
        if (i >= 8 && i <= 30) begin
          bus.data_in = $urandom;
          bus.req     = (i % 3 == 0) ? 4'b0110 : 4'b0000;
        end else if (i == 31) begin
          bus.req = 4'b0000;
        end
      end
      if (i < FRAME - 1) tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] a;
  int         t;
  logic [9:0] bits;
  int         bn;
  logic [1:0] gids [5];
  int         times [5];
  int         ack_n;

  initial begin
    bus.req     = 4'd0;
    bus.data_in = 32'd0;
    rst_n       = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_gid", 32'(bus.grant_id), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request, byte A5
    bus.data_in = 32'h0000_00A5;
    bus.req     = 4'b0001;
    wait_ack(a, t);
    check("t1_ack", 32'(a), 32'h1);
    check("t1_gid", 32'(bus.grant_id), 32'd0);
    bus.req = 4'b0000;
    capture(1'b0, bits, bn);
    check("t1_frame", 32'(bits), 32'(10'b1101001010));
    check("t1_busy_len", 32'(bn), 32'd40);
    tick();
    check("t1_idle", 32'(bus.busy), 32'd0);

    // Round robin with all four requesting
    do_reset();
    bus.data_in = 32'hF0_81_7E_C3;
    bus.req     = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, t);
      gids[k]  = bus.grant_id;
      times[k] = t;
    end
    bus.req = 4'b0000;
    check("t2_order", 32'({gids[0], gids[1], gids[2], gids[3], gids[4]}), 32'(10'b00_01_10_11_00));
    for (int k = 1; k < 5; k++) check("t2_spacing", 32'(times[k] - times[k-1]), 32'd40);
    wait_idle();

    // Fairness between requesters 0 and 2
    do_reset();
    bus.data_in = 32'h00_3C_00_96;
    bus.req     = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      wait_ack(a, t);
      gids[k] = bus.grant_id;
    end
    bus.req = 4'b0000;
    check("t3_order", 32'({gids[0], gids[1], gids[2]}), 32'(6'b00_10_00));
    wait_idle();

    // Inputs changing during DATA must not affect the frame
    tick();
    bus.data_in = 32'h0000_3C00;
    bus.req     = 4'b0010;
    wait_ack(a, t);
    check("t4_ack", 32'(a), 32'h2);
    bus.req = 4'b0000;
    capture(1'b1, bits, bn);
    check("t4_frame", 32'(bits), 32'({1'b1, 8'h3C, 1'b0}));
    tick();
    wait_idle();

    // Reset during data bit 3 aborts the frame
    bus.data_in = 32'h0000_5A00;
    bus.req     = 4'b0010;
    wait_ack(a, t);
    for (int i = 0; i < 17; i++) tick();
    rst_n = 1'b0;
    tick();
    check("t5_tx", 32'(bus.tx), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_gid", 32'(bus.grant_id), 32'd0);
    check("t5_ack", 32'(bus.ack), 32'd0);
    rst_n = 1'b1;
    wait_ack(a, t);
    check("t5_regrant_ack", 32'(a), 32'h2);
    check("t5_regrant_gid", 32'(bus.grant_id), 32'd1);
    check("t5_latency", 32'(t), 32'(cyc));
    bus.req = 4'b0000;
    wait_idle();

    // Short pulse on req[2] while busy is never served
    bus.data_in = 32'h00_77_00_11;
    bus.req     = 4'b0001;
    wait_ack(a, t);
    bus.req = 4'b0000;
    ack_n = 0;
    for (int i = 0; i < 10; i++) tick();
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.ack != 4'd0) ack_n++;
    end
    check("t6_no_ack", 32'(ack_n), 32'd0);
    check("t6_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
